// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and default sizing for the register-bank arbiter.
package dff_bank_arbiter_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Round-robin selector: first asserted req at or after ptr, wrapping NREQ-1 -> 0.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);

  logic [IW:0] pos;
  logic        found;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (!found && req[IW'(pos)]) begin
        found               = 1'b1;
        win_idx             = IW'(pos);
        win_oh[IW'(pos)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Arbitrates NREQ requesters onto one external WIDTH-bit register bank:
// IDLE -> WRITE (one cycle, reg_en) -> ACK (one cycle, ack pulse) -> IDLE.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic                       reg_en,
  output logic [WIDTH-1:0]           reg_d,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  // Data is captured at grant so a winner may drop req early without corrupting the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      owner  <= '0;
      reg_d  <= '0;
      gnt    <= '0;
      ack    <= '0;
      reg_en <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt    <= pick_oh;
            win    <= pick_idx;
            reg_d  <= wdata[pick_idx];
            reg_en <= 1'b1;
            busy   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          gnt    <= '0;
          reg_en <= 1'b0;
          ack    <= gnt;
          owner  <= win;
          ptr    <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          state  <= ACK;
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt    <= '0;
          ack    <= '0;
          reg_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed scenarios plus a randomized
// run checked against a transaction-timing reference model.
module tb_dff_bank_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req;
  logic [N-1:0][W-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;
  logic               reg_en;
  logic [W-1:0]       reg_d;
  logic [1:0]         owner;
  logic               busy;

  int compared   = 0;
  int mismatched = 0;

  dff_bank_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .reg_en (reg_en),
    .reg_d  (reg_d),
    .owner  (owner),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin: first set bit at or after p, modulo N.
  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++)
      if (r[2'((p + k) % int'(N))]) return (p + k) % int'(N);
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[2'(i)] = 1'b1;
    return v;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < int'(N); i++) wdata[i] = W'($urandom);
  endtask

  task automatic test_reset();
    int exp_idx;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req = N'($urandom);
      randomize_data();
      step();
      compared++;
      if ({gnt, ack, reg_en, reg_d, owner, busy} !== '0) begin
        mismatched++;
        $display("FAIL reset_hold: got gnt=%b ack=%b en=%b d=%h own=%0d busy=%b, required all 0",
                 gnt, ack, reg_en, reg_d, owner, busy);
      end
    end
    req = N'($urandom_range(1, 15));
    randomize_data();
    rst = 1'b1;
    exp_idx = rr_ref(req, 0);
    step();
    compared++;
    if (gnt !== onehot(exp_idx) || reg_en !== 1'b1 || reg_d !== wdata[2'(exp_idx)]) begin
      mismatched++;
      $display("FAIL reset_first_grant: got gnt=%b en=%b d=%h, required gnt=%b en=1 d=%h",
               gnt, reg_en, reg_d, onehot(exp_idx), wdata[2'(exp_idx)]);
    end
    step();
    req = '0;
    step();
    step();
  endtask

  task automatic test_single();
    randomize_data();
    wdata[1] = 8'hA5;
    req = 4'b0010;
    step();
    compared++;
    if (gnt !== 4'b0010 || reg_en !== 1'b1 || reg_d !== 8'hA5 || ack !== 4'b0000 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_write: got gnt=%b en=%b d=%h ack=%b busy=%b, required 0010/1/a5/0000/1",
               gnt, reg_en, reg_d, ack, busy);
    end
    step();
    compared++;
    if (ack !== 4'b0010 || gnt !== 4'b0000 || reg_en !== 1'b0 || owner !== 2'd1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_ack: got ack=%b gnt=%b en=%b own=%0d busy=%b, required 0010/0000/0/1/1",
               ack, gnt, reg_en, owner, busy);
    end
    req = '0;
    step();
    compared++;
    if (busy !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0000) begin
      mismatched++;
      $display("FAIL single_idle: got busy=%b ack=%b gnt=%b, required 0/0000/0000", busy, ack, gnt);
    end
  endtask

  task automatic test_fairness();
    int gcyc[$];
    int gidx[$];
    int idx;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    randomize_data();
    req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (gnt !== '0) begin
        idx = -1;
        for (int k = 0; k < int'(N); k++) if (gnt[k]) idx = k;
        gcyc.push_back(c);
        gidx.push_back(idx);
        compared++;
        if (idx < 0 || reg_d !== wdata[2'(idx)]) begin
          mismatched++;
          $display("FAIL fair_data: got d=%h for gnt=%b", reg_d, gnt);
        end
      end
    end
    req = '0;
    step();
    step();
    compared++;
    if (gidx.size() != 5 || gcyc.size() != 5) begin
      mismatched++;
      $display("FAIL fair_count: got %0d grants, required 5", gidx.size());
    end else begin
      for (int n = 0; n < 5; n++) begin
        compared++;
        if (gidx[n] != n % int'(N) || gcyc[n] != 1 + 3 * n) begin
          mismatched++;
          $display("FAIL fair_order[%0d]: got idx=%0d cycle=%0d, required idx=%0d cycle=%0d",
                   n, gidx[n], gcyc[n], n % int'(N), 1 + 3 * n);
        end
      end
    end
  endtask

  task automatic test_early_drop();
    randomize_data();
    wdata[2] = 8'h3C;
    req = 4'b0100;
    step();
    compared++;
    if (gnt !== 4'b0100 || reg_en !== 1'b1 || reg_d !== 8'h3C) begin
      mismatched++;
      $display("FAIL drop_write: got gnt=%b en=%b d=%h, required 0100/1/3c", gnt, reg_en, reg_d);
    end
    req = 4'b0001;
    step();
    compared++;
    if (ack !== 4'b0100 || gnt !== 4'b0000 || reg_d !== 8'h3C || owner !== 2'd2) begin
      mismatched++;
      $display("FAIL drop_ack: got ack=%b gnt=%b d=%h own=%0d, required 0100/0000/3c/2",
               ack, gnt, reg_d, owner);
    end
    step();
    compared++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_idle: got gnt=%b busy=%b, required 0000/0", gnt, busy);
    end
    step();
    compared++;
    if (gnt !== 4'b0001 || reg_d !== wdata[0]) begin
      mismatched++;
      $display("FAIL drop_next: got gnt=%b d=%h, required 0001/%h", gnt, reg_d, wdata[0]);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    randomize_data();
    req = 4'b1000;
    step();
    compared++;
    if (gnt !== 4'b1000 || reg_en !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_write: got gnt=%b en=%b, required 1000/1", gnt, reg_en);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (reg_en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_async: got en=%b gnt=%b busy=%b, required 0/0000/0", reg_en, gnt, busy);
    end
    step();
    compared++;
    if (ack !== 4'b0000) begin
      mismatched++;
      $display("FAIL rstmid_noack: got ack=%b, required 0000", ack);
    end
    req = 4'b1001;
    rst = 1'b1;
    step();
    compared++;
    if (gnt !== 4'b0001 || reg_d !== wdata[0]) begin
      mismatched++;
      $display("FAIL rstmid_ptr0: got gnt=%b d=%h, required 0001/%h", gnt, reg_d, wdata[0]);
    end
    step();
    compared++;
    if (ack !== 4'b0001) begin
      mismatched++;
      $display("FAIL rstmid_ack: got ack=%b, required 0001", ack);
    end
    req = '0;
    step();
  endtask

  task automatic test_wrap();
    randomize_data();
    req = 4'b0100;
    step();
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++;
      $display("FAIL wrap_pre: got gnt=%b, required 0100", gnt);
    end
    step();
    req = 4'b1001;
    step();
    step();
    compared++;
    if (gnt !== 4'b1000 || reg_d !== wdata[3]) begin
      mismatched++;
      $display("FAIL wrap_to3: got gnt=%b d=%h, required 1000/%h", gnt, reg_d, wdata[3]);
    end
    step();
    compared++;
    if (ack !== 4'b1000 || owner !== 2'd3) begin
      mismatched++;
      $display("FAIL wrap_ack3: got ack=%b own=%0d, required 1000/3", ack, owner);
    end
    req = 4'b0001;
    step();
    step();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++;
      $display("FAIL wrap_to0: got gnt=%b, required 0001", gnt);
    end
    req = '0;
    step();
    step();
  endtask

  // Random requesters that obey the handshake; model predicts grant cycle, winner and data.
  task automatic test_random();
    int m_ptr, m_owner, g_cycle, g_idx, next_ok;
    logic [W-1:0] m_regd;
    logic [N-1:0] r_s, exp_gnt, exp_ack;
    logic exp_en, exp_busy;
    rst = 1'b0;
    req = '0;
    #1;
    rst = 1'b1;
    m_ptr = 0; m_owner = 0; m_regd = '0;
    g_cycle = -10; g_idx = 0; next_ok = 1;
    for (int n = 1; n <= 300; n++) begin
      r_s = req;
      step();
      if (n >= next_ok && r_s != '0) begin
        g_idx   = rr_ref(r_s, m_ptr);
        g_cycle = n;
        m_regd  = wdata[2'(g_idx)];
        next_ok = n + 3;
        m_ptr   = (g_idx + 1) % int'(N);
      end
      exp_gnt  = (n == g_cycle) ? onehot(g_idx) : '0;
      exp_ack  = (n == g_cycle + 1) ? onehot(g_idx) : '0;
      exp_en   = (n == g_cycle);
      exp_busy = (n == g_cycle) || (n == g_cycle + 1);
      if (n == g_cycle + 1) m_owner = g_idx;
      compared++;
      if (gnt !== exp_gnt) begin
        mismatched++;
        $display("FAIL rand_gnt@%0d: got %b, required %b", n, gnt, exp_gnt);
      end
      compared++;
      if (ack !== exp_ack) begin
        mismatched++;
        $display("FAIL rand_ack@%0d: got %b, required %b", n, ack, exp_ack);
      end
      compared++;
      if (reg_en !== exp_en || busy !== exp_busy) begin
        mismatched++;
        $display("FAIL rand_en_busy@%0d: got en=%b busy=%b, required en=%b busy=%b",
                 n, reg_en, busy, exp_en, exp_busy);
      end
      compared++;
      if (reg_d !== m_regd || owner !== 2'(m_owner)) begin
        mismatched++;
        $display("FAIL rand_d_owner@%0d: got d=%h own=%0d, required d=%h own=%0d",
                 n, reg_d, owner, m_regd, m_owner);
      end
      for (int i = 0; i < int'(N); i++) begin
        if (exp_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          wdata[i] = W'($urandom);
          req[i]   = 1'b1;
        end
      end
    end
    req = '0;
    step();
    step();
  endtask

  initial begin
    rst   = 1'b0;
    req   = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_early_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
